multicycle_control_fsm: RTL and testbench

Moore-style control state machine that sequences the multicycle RV32I datapath: shared memory for instruction and data, instruction register, one ALU reused for PC increment, address and result computation. It walks each instruction through fetch, decode, execute, memory and writeback states. Each cycle it drives every datapath mux select, enable and write strobe. It sits beside the ALU decoder, which consumes `ALUOp`, and stalls on a memory ready handshake.

---
 rtl/multicycle_control_fsm.sv | 168 ++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 138 +++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for a multicycle RV32I datapath: fetch/decode/execute/memory/writeback
// sequencing with a shared-memory ready handshake and asynchronous active-low reset.
module multicycle_control_fsm #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         Op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               IRWrite,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         ImmSrc,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  state_t state_q, state_d;

  logic       pc_update, branch;
  logic       adr_src, ir_write, mem_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
        state_d    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        unique case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        state_d   = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset masks the strobes combinationally so an abort takes effect in the same cycle.
  always_comb begin
    PCWrite    = rst & (pc_update | (branch & zero));
    AdrSrc     = rst & adr_src;
    IRWrite    = rst & ir_write;
    MemWrite   = rst & mem_write;
    RegWrite   = rst & reg_write;
    illegal_op = rst & illegal;
    ResultSrc  = rst ? result_src : 2'b00;
    ALUSrcA    = rst ? alu_src_a  : 2'b00;
    ALUSrcB    = rst ? alu_src_b  : 2'b00;
    ALUOp      = rst ? alu_op     : 2'b00;
  end

  always_comb begin
    unique case (Op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class cycle by cycle
// and compares state plus the packed output vector against hand-written expectations.
module tb_multicycle_control_fsm;

  logic       clk, rst, zero, mem_ready;
  logic [6:0] Op;
  logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, illegal_op;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic [3:0] state;

  int unsigned passed = 0;
  int unsigned total  = 0;

  multicycle_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .Op(Op), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ImmSrc(ImmSrc), .illegal_op(illegal_op), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_op}
  function automatic logic [15:0] mk(logic pcw, logic adr, logic irw, logic mw, logic rw,
                                     logic [1:0] rs, logic [1:0] sa, logic [1:0] sb,
                                     logic [1:0] op, logic [1:0] imm, logic ill);
    return {pcw, adr, irw, mw, rw, rs, sa, sb, op, imm, ill};
  endfunction

  logic [15:0] obs;
  assign obs = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ALUOp, ImmSrc, illegal_op};

  task automatic chk(string tag, logic [15:0] o, logic [15:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, o, e);
  endtask

  // Check state and outputs now, without advancing.
  task automatic look(string tag, logic [3:0] es, logic [15:0] eo);
    #1;
    chk({tag, ".state"}, {12'd0, state}, {12'd0, es});
    chk({tag, ".outs"}, obs, eo);
  endtask

  // Apply inputs, check mid-cycle, then advance to just after the next rising edge.
  task automatic step(string tag, logic mr, logic z, logic [3:0] es, logic [15:0] eo);
    mem_ready = mr;
    zero      = z;
    look(tag, es, eo);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; mem_ready = 1'b1; zero = 1'b0; Op = 7'b0100011;

    // Reset held: everything 0 except ImmSrc (sw -> 01)
    look("rst0", 4'd0, mk(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b01,0));
    @(posedge clk); #1;
    look("rst1", 4'd0, mk(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b01,0));
    rst = 1'b1;

    // sw partway, then reset in MEMWRITE
    step("sw0_fetch",  1, 0, 4'd0, mk(1,0,1,0,0,2'b10,2'b00,2'b10,2'b00,2'b01,0));
    step("sw0_decode", 1, 0, 4'd1, mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b01,0));
    step("sw0_memadr", 1, 0, 4'd2, mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b01,0));
    look("sw0_memwr",  4'd5, mk(0,1,0,1,0,2'b00,2'b00,2'b00,2'b00,2'b01,0));
    rst = 1'b0;
    look("abort",      4'd0, mk(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b01,0));
    @(posedge clk); #1;
    look("abort_hold", 4'd0, mk(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b01,0));
    rst = 1'b1;

    // lw with one stall in MEMREAD
    Op = 7'b0000011;
    step("lw_fetch",   1, 0, 4'd0, mk(1,0,1,0,0,2'b10,2'b00,2'b10,2'b00,2'b00,0));
    step("lw_decode",  1, 0, 4'd1, mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0));
    step("lw_memadr",  1, 0, 4'd2, mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b00,0));
    step("lw_rd_wait", 0, 0, 4'd3, mk(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0));
    step("lw_memread", 1, 0, 4'd3, mk(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0));
    step("lw_memwb",   1, 0, 4'd4, mk(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,2'b00,0));

    // sw with 3 wait cycles: MemWrite held 4 cycles
    Op = 7'b0100011;
    step("sw_fetch",   1, 0, 4'd0, mk(1,0,1,0,0,2'b10,2'b00,2'b10,2'b00,2'b01,0));
    step("sw_decode",  1, 0, 4'd1, mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b01,0));
    step("sw_memadr",  1, 0, 4'd2, mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b01,0));
    for (int i = 0; i < 3; i++)
      step("sw_wait",  0, 0, 4'd5, mk(0,1,0,1,0,2'b00,2'b00,2'b00,2'b00,2'b01,0));
    step("sw_memwr",   1, 0, 4'd5, mk(0,1,0,1,0,2'b00,2'b00,2'b00,2'b00,2'b01,0));

    // beq taken then not taken
    Op = 7'b1100011;
    step("beqt_fetch", 1, 0, 4'd0, mk(1,0,1,0,0,2'b10,2'b00,2'b10,2'b00,2'b10,0));
    step("beqt_dec",   1, 0, 4'd1, mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b10,0));
    step("beqt_beq",   1, 1, 4'd10, mk(1,0,0,0,0,2'b00,2'b10,2'b00,2'b01,2'b10,0));
    step("beqn_fetch", 1, 0, 4'd0, mk(1,0,1,0,0,2'b10,2'b00,2'b10,2'b00,2'b10,0));
    step("beqn_dec",   1, 1, 4'd1, mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b10,0));
    step("beqn_beq",   0, 0, 4'd10, mk(0,0,0,0,0,2'b00,2'b10,2'b00,2'b01,2'b10,0));

    // jal
    Op = 7'b1101111;
    step("jal_fetch",  1, 0, 4'd0, mk(1,0,1,0,0,2'b10,2'b00,2'b10,2'b00,2'b11,0));
    step("jal_dec",    1, 0, 4'd1, mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b11,0));
    step("jal_jal",    1, 0, 4'd9, mk(1,0,0,0,0,2'b00,2'b01,2'b10,2'b00,2'b11,0));
    step("jal_aluwb",  1, 0, 4'd8, mk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b11,0));

    // R-type, mem_ready low where it must be ignored
    Op = 7'b0110011;
    step("r_fetch",    1, 0, 4'd0, mk(1,0,1,0,0,2'b10,2'b00,2'b10,2'b00,2'b00,0));
    step("r_dec",      0, 0, 4'd1, mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0));
    step("r_execr",    0, 1, 4'd6, mk(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,2'b00,0));
    step("r_aluwb",    0, 0, 4'd8, mk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b00,0));

    // I-type ALU
    Op = 7'b0010011;
    step("i_fetch",    1, 0, 4'd0, mk(1,0,1,0,0,2'b10,2'b00,2'b10,2'b00,2'b00,0));
    step("i_dec",      1, 0, 4'd1, mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0));
    step("i_execi",    1, 0, 4'd7, mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,2'b00,0));
    step("i_aluwb",    1, 0, 4'd8, mk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b00,0));

    // Illegal opcode, then a 5-cycle fetch stall
    Op = 7'b1111111;
    step("ill_fetch",  1, 0, 4'd0, mk(1,0,1,0,0,2'b10,2'b00,2'b10,2'b00,2'b00,0));
    step("ill_dec",    1, 0, 4'd1, mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,1));
    for (int i = 0; i < 5; i++)
      step("stall",    0, 0, 4'd0, mk(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,2'b00,0));
    step("stall_end",  1, 0, 4'd0, mk(1,0,1,0,0,2'b10,2'b00,2'b10,2'b00,2'b00,0));
    look("post_stall", 4'd1, mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
